// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled 8N1 UART receive engine for the uart block RX FIFO.
// Synchronises the serial line, qualifies start bits, deserialises LSB-first
// and checks the stop bit, then presents each byte on a valid/ready port.
// Build option: define MAJORITY_VOTE_EN to take every bit as the 2-of-3
// majority of the samples at ticks MID-1, MID and MID+1 (decided at MID+1);
// otherwise a single sample at the MID tick is used.
module uart_rx_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_en_i,
    input  logic [15:0]           baud_div_i,
    input  logic                  uart_rx_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_err_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   sync_s;
    logic                   fall_s;

    // Tick generator and oversample counter
    logic [15:0]      tick_div_s;
    logic [15:0]      tick_div_r;
    logic [15:0]      tick_cnt_r;
    logic [CNT_W-1:0] s_cnt_r;
    logic             tick_s;
    logic             eob_s;
    logic             decide_s;
    logic             bit_val_s;

    // FSM and datapath
    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [IDX_W-1:0]      bit_idx_r;
    logic [IDX_W-1:0]      bit_idx_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  deliver_s;

    // Output registers
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  rx_valid_r;
    logic                  frame_err_r;
    logic                  overrun_r;
    logic                  busy_r;

    assign sync_s = sync_r[SYNC_STAGES-1];
    // A start edge needs the previous synchronised value high, so a line
    // stuck low cannot retrigger until it has gone high again.
    assign fall_s = prev_r & ~sync_s;

    // Bring the asynchronous line into the clock domain and keep one delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx_i};
            prev_r <= sync_s;
        end
    end

    // Derive the per-tick clock count from the bit divisor, never below one clock
    always_comb begin
        tick_div_s = baud_div_i >> CNT_W;
        if (tick_div_s == 16'd0) begin
            tick_div_s = 16'd1;
        end else begin
            tick_div_s = tick_div_s;
        end
    end

    assign tick_s = (state_r != S_IDLE) && (tick_cnt_r == (tick_div_r - 16'd1));
    assign eob_s  = tick_s && (s_cnt_r == END_CNT);

    // Tick and oversample counters: held cleared in IDLE so they restart at the start edge
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            tick_cnt_r <= 16'd0;
            tick_div_r <= 16'd1;
            s_cnt_r    <= '0;
        end else if (state_r == S_IDLE) begin
            tick_cnt_r <= 16'd0;
            tick_div_r <= tick_div_s;
            s_cnt_r    <= '0;
        end else if (tick_s) begin
            // Divisor is re-read on every reload so a new BAUD value applies from the next tick
            tick_cnt_r <= 16'd0;
            tick_div_r <= tick_div_s;
            s_cnt_r    <= (s_cnt_r == END_CNT) ? '0 : s_cnt_r + 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end

`ifdef MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] MID_M1_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID_P1_CNT = CNT_W'(OVERSAMPLE / 2 + 1);

    logic smp_early_r;
    logic smp_mid_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the MID-1 and MID samples; the MID+1 sample is taken live at decision time
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            smp_early_r <= 1'b1;
            smp_mid_r   <= 1'b1;
        end else begin
            if (tick_s && (s_cnt_r == MID_M1_CNT)) begin
                smp_early_r <= sync_s;
            end
            if (tick_s && (s_cnt_r == MID_CNT)) begin
                smp_mid_r <= sync_s;
            end
        end
    end

    assign decide_s  = tick_s && (s_cnt_r == MID_P1_CNT);
    assign bit_val_s = maj3(smp_early_r, smp_mid_r, sync_s);
`else
    assign decide_s  = tick_s && (s_cnt_r == MID_CNT);
    assign bit_val_s = sync_s;
`endif

    // Frame sequencing: start qualification, data bit counting, stop sampling
    always_comb begin
        state_nxt_s   = state_r;
        bit_idx_nxt_s = bit_idx_r;
        deliver_s     = 1'b0;
        if (!rx_en_i) begin
            // Disabling abandons any partial frame silently
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (fall_s) begin
                        state_nxt_s = S_START;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_START: begin
                    if (decide_s && bit_val_s) begin
                        state_nxt_s = S_IDLE;
                    end else if (eob_s) begin
                        state_nxt_s   = S_DATA;
                        bit_idx_nxt_s = '0;
                    end else begin
                        state_nxt_s = S_START;
                    end
                end
                S_DATA: begin
                    if (eob_s) begin
                        if (bit_idx_r == LAST_BIT) begin
                            state_nxt_s = S_STOP;
                        end else begin
                            bit_idx_nxt_s = bit_idx_r + 1'b1;
                        end
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop to gain half a bit of resync margin
                    if (decide_s) begin
                        deliver_s   = 1'b1;
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_STOP;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // FSM state, bit index and the registered busy flag
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_r   <= S_IDLE;
            bit_idx_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            busy_r    <= (state_nxt_s != S_IDLE);
        end
    end

    // Deserialiser: shift each decided data bit in from the top so the first bit ends at the LSB
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            shift_r <= '0;
        end else if ((state_r == S_DATA) && decide_s) begin
            shift_r <= {bit_val_s, shift_r[DATA_WIDTH-1:1]};
        end
    end

    // Output holding register with valid/ready handshake and overrun detection
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (deliver_s) begin
                if (!rx_valid_r || rx_ready_i) begin
                    rx_data_r   <= shift_r;
                    frame_err_r <= ~bit_val_s;
                    rx_valid_r  <= 1'b1;
                end else begin
                    // Held byte not yet taken: drop the new one and flag it
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready_i) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign rx_data_o     = rx_data_r;
    assign rx_valid_o    = rx_valid_r;
    assign frame_err_o   = frame_err_r;
    assign overrun_err_o = overrun_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a 434-clock bit time.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 434;

    logic       clk;
    logic       rst_ni;
    logic       rx_en;
    logic [15:0] baud_div;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters observed away from the active edge
    int         xfer_cnt   = 0;
    int         valid_cyc  = 0;
    int         ovr_cnt    = 0;
    logic [7:0] last_data  = 8'h00;
    logic       last_ferr  = 1'b0;

    int x0;
    int v0;
    int o0;

    uart_rx_core #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rx_en_i      (rx_en),
        .baud_div_i   (baud_div),
        .uart_rx_i    (uart_rx),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .frame_err_o  (frame_err),
        .overrun_err_o(overrun_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A transfer happens at the next rising edge whenever valid and ready are both high here
    always @(negedge clk) begin
        if (rx_valid) valid_cyc++;
        if (overrun_err) ovr_cnt++;
        if (rx_valid && rx_ready) begin
            xfer_cnt++;
            last_data = rx_data;
            last_ferr = frame_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        uart_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_clks(BIT_CLKS);
        end
        uart_rx = stop_b;
        wait_clks(BIT_CLKS);
        uart_rx = 1'b1;
    endtask

    initial begin
        rst_ni   = 1'b1;
        rx_en    = 1'b1;
        baud_div = 16'd434;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        wait_clks(4);

        // Reset values
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ovr", {31'd0, overrun_err}, 32'd0);
        rst_ni = 1'b0;
        wait_clks(20);

        // Good frame 0xA5
        x0 = xfer_cnt; v0 = valid_cyc; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clks(200);
        chk("a5_xfers", xfer_cnt - x0, 32'd1);
        chk("a5_valid_cycles", valid_cyc - v0, 32'd1);
        chk("a5_data", {24'd0, last_data}, 32'h0000_00A5);
        chk("a5_ferr", {31'd0, last_ferr}, 32'd0);
        chk("a5_no_overrun", ovr_cnt - o0, 32'd0);
        chk("a5_idle", {31'd0, busy}, 32'd0);

        // Short low glitch: start rejected at the mid sample
        x0 = xfer_cnt;
        uart_rx = 1'b0;
        wait_clks(100);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_clks(35);
        uart_rx = 1'b1;
        wait_clks(600);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_no_byte", xfer_cnt - x0, 32'd0);

        // Bad stop bit, then a good frame
        x0 = xfer_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clks(1000);
        chk("3c_data", {24'd0, last_data}, 32'h0000_003C);
        chk("3c_ferr", {31'd0, last_ferr}, 32'd1);
        chk("3c_no_retrigger", {31'd0, busy}, 32'd0);
        send_frame(8'h42, 1'b1);
        wait_clks(200);
        chk("42_data", {24'd0, last_data}, 32'h0000_0042);
        chk("42_ferr", {31'd0, last_ferr}, 32'd0);
        chk("3c_42_xfers", xfer_cnt - x0, 32'd2);

        // Overrun while the FIFO is full
        rx_ready = 1'b0;
        x0 = xfer_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        wait_clks(200);
        chk("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("ovr_first_data", {24'd0, rx_data}, 32'h0000_0011);
        chk("ovr_none_yet", ovr_cnt - o0, 32'd0);
        send_frame(8'h22, 1'b1);
        wait_clks(200);
        chk("ovr_data_stable", {24'd0, rx_data}, 32'h0000_0011);
        chk("ovr_ferr_stable", {31'd0, frame_err}, 32'd0);
        chk("ovr_one_pulse", ovr_cnt - o0, 32'd1);
        rx_ready = 1'b1;
        wait_clks(2);
        chk("ovr_drain_valid", {31'd0, rx_valid}, 32'd0);
        chk("ovr_drain_xfers", xfer_cnt - x0, 32'd1);
        chk("ovr_drain_data", {24'd0, last_data}, 32'h0000_0011);

        // Disable during data bit 4 of 0x77, abandon the frame, then receive 0x5A
        x0 = xfer_cnt;
        uart_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (8'h77 >> i) & 8'h01;
            wait_clks(BIT_CLKS);
        end
        uart_rx = 1'b1;
        wait_clks(200);
        chk("dis_busy_before", {31'd0, busy}, 32'd1);
        rx_en = 1'b0;
        wait_clks(2);
        chk("dis_busy_after", {31'd0, busy}, 32'd0);
        rx_en = 1'b1;
        wait_clks(1000);
        send_frame(8'h5A, 1'b1);
        wait_clks(200);
        chk("dis_only_one", xfer_cnt - x0, 32'd1);
        chk("dis_data", {24'd0, last_data}, 32'h0000_005A);

        // Asynchronous reset in the middle of a frame
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        wait_clks(200);
        chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        chk("pre_rst_data", {24'd0, rx_data}, 32'h0000_0033);
        uart_rx = 1'b0;
        wait_clks(1000);
        #2 rst_ni = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_async_data", {24'd0, rx_data}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        uart_rx = 1'b1;
        rx_ready = 1'b1;
        wait_clks(5);
        rst_ni = 1'b0;
        wait_clks(1000);
        x0 = xfer_cnt;
        send_frame(8'hFF, 1'b1);
        wait_clks(200);
        chk("ff_xfers", xfer_cnt - x0, 32'd1);
        chk("ff_data", {24'd0, last_data}, 32'h0000_00FF);
        chk("ff_ferr", {31'd0, last_ferr}, 32'd0);

`ifdef MAJORITY_VOTE_EN
        // One-tick inverted glitch over the MID sample of data bit 0 of 0x01
        wait_clks(500);
        x0 = xfer_cnt;
        uart_rx = 1'b0;
        wait_clks(BIT_CLKS);
        uart_rx = 1'b1;
        wait_clks(230);
        uart_rx = 1'b0;
        wait_clks(27);
        uart_rx = 1'b1;
        wait_clks(BIT_CLKS - 257);
        uart_rx = 1'b0;
        wait_clks(7 * BIT_CLKS);
        uart_rx = 1'b1;
        wait_clks(BIT_CLKS);
        wait_clks(200);
        chk("mv_xfers", xfer_cnt - x0, 32'd1);
        chk("mv_data", {24'd0, last_data}, 32'h0000_0001);
        chk("mv_ferr", {31'd0, last_ferr}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
